// File: rtl/gf2_polydiv.sv
// -----------------------------------------------------------------------------
// gf2_polydiv
//
// Bit-serial GF(2) polynomial divider. Given a dividend a (AW coefficients) and
// a monic divisor b (BW coefficients, degree BW-1) it returns quotient q and
// remainder r with a = q*b XOR r (carry-less product), deg r < BW-1.
// One quotient bit is resolved per clock, from the top coefficient down.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   dividend/divisor offered
//   in_ready   block can accept (high only in IDLE, also during reset)
//   a[0:AW-1]  dividend, a[i] is the coefficient of x^i
//   b[0:BW-1]  divisor,  b[i] is the coefficient of x^i
//   out_valid  result held
//   out_ready  consumer takes the result
//   q[0:QW-1]  quotient,  q[i] is the coefficient of x^i
//   r[0:RW-1]  remainder, r[i] is the coefficient of x^i
//   err        divisor rejected because its top coefficient is zero
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The input side is accepted only in IDLE; the result is offered in DONE
// and stays stable until the edge on which out_ready is high.
// -----------------------------------------------------------------------------
module gf2_polydiv #(
  parameter  int AW = 27,
  parameter  int BW = 14,
  localparam int QW = AW - BW + 1,
  localparam int RW = BW - 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [0:AW-1] a,
  input  logic [0:BW-1] b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [0:QW-1] q,
  output logic [0:RW-1] r,
  output logic          err
);

  localparam int CW = (QW > 1) ? $clog2(QW) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Control state kept together so the FSM position and step count can be
  // observed as one unit.
  typedef struct packed {
    state_t          state;
    logic [CW-1:0]   cnt;
  } ctrl_t;

  ctrl_t          ctrl_q, ctrl_d;
  // Internally every polynomial is a little-endian packed vector: bit i is x^i.
  logic [AW-1:0]  rem_q, rem_d;       // working remainder R
  logic [BW-1:0]  div_q, div_d;       // latched divisor
  logic [QW-1:0]  quo_q, quo_d;       // quotient being built
  logic [RW-1:0]  rout_q, rout_d;     // remainder presented on r
  logic           err_q, err_d;
  logic           out_valid_q, out_valid_d;

  logic [AW-1:0]  a_le;
  logic [BW-1:0]  b_le;
  logic [CW-1:0]  shift;              // i-(BW-1) for the coefficient under test
  logic [AW-1:0]  probe;              // one-hot mask selecting R[i]
  logic [AW-1:0]  div_shift;          // divisor aligned under R[i]
  logic           top_bit;

  // Port arrays are ascending; convert to the internal bit order.
  always_comb begin
    a_le = '0;
    b_le = '0;
    for (int i = 0; i < AW; i++) a_le[i] = a[i];
    for (int i = 0; i < BW; i++) b_le[i] = b[i];
  end

  always_comb begin
    q = '0;
    r = '0;
    for (int i = 0; i < QW; i++) q[i] = quo_q[i];
    for (int i = 0; i < RW; i++) r[i] = rout_q[i];
  end

  assign in_ready  = (ctrl_q.state == S_IDLE);
  assign out_valid = out_valid_q;
  assign err       = err_q;

  // Step cnt examines coefficient i = AW-1-cnt, i.e. shift = QW-1-cnt.
  assign shift     = CW'(QW - 1) - ctrl_q.cnt;
  assign probe     = AW'(1) << (32'(shift) + (BW - 1));
  assign top_bit   = |(rem_q & probe);
  assign div_shift = AW'(div_q) << shift;

  always_comb begin
    ctrl_d      = ctrl_q;
    rem_d       = rem_q;
    div_d       = div_q;
    quo_d       = quo_q;
    rout_d      = rout_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;

    case (ctrl_q.state)
      S_IDLE: begin
        if (in_valid) begin
          rem_d      = a_le;
          div_d      = b_le;
          quo_d      = '0;
          ctrl_d.cnt = '0;
          if (b_le[BW-1]) begin
            ctrl_d.state = S_RUN;
          end else begin
            // Non-monic divisor: report straight away, no division steps.
            ctrl_d.state = S_DONE;
            err_d        = 1'b1;
            rout_d       = '0;
            out_valid_d  = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (top_bit) begin
          rem_d = rem_q ^ div_shift;
          quo_d = quo_q | (QW'(1) << shift);
        end
        if (ctrl_q.cnt == CW'(QW - 1)) begin
          // Last step: everything at or above x^(BW-1) has been cancelled.
          rout_d       = rem_d[RW-1:0];
          ctrl_d.state = S_DONE;
          out_valid_d  = 1'b1;
        end else begin
          ctrl_d.cnt = ctrl_q.cnt + CW'(1);
        end
      end

      S_DONE: begin
        if (out_ready) begin
          out_valid_d  = 1'b0;
          err_d        = 1'b0;
          ctrl_d.state = S_IDLE;
        end
      end

      default: begin
        ctrl_d.state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q      <= '{state: S_IDLE, cnt: '0};
      rem_q       <= '0;
      div_q       <= '0;
      quo_q       <= '0;
      rout_q      <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_d;
      rem_q       <= rem_d;
      div_q       <= div_d;
      quo_q       <= quo_d;
      rout_q      <= rout_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_gf2_polydiv.sv
// -----------------------------------------------------------------------------
// tb_gf2_polydiv
//
// Self-checking bench for gf2_polydiv: a table of hand-computed divisions,
// hand-written sequences for back-pressure and reset-during-run, and a batch
// of random monic divisions checked with a carry-less multiply model.
// -----------------------------------------------------------------------------
module tb_gf2_polydiv;

  localparam int AW = 27;
  localparam int BW = 14;
  localparam int QW = AW - BW + 1;
  localparam int RW = BW - 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [0:AW-1] a;
  logic [0:BW-1] b;
  logic          out_valid;
  logic          out_ready;
  logic [0:QW-1] q;
  logic [0:RW-1] r;
  logic          err;

  always #5 clk = ~clk;

  gf2_polydiv #(.AW(AW), .BW(BW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .err       (err)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [QW+RW:0] exp_q[$];   // {q, r, err}

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // ---------------- helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ab(input logic [AW-1:0] av, input logic [BW-1:0] bv);
    for (int i = 0; i < AW; i++) a[i] = av[i];
    for (int i = 0; i < BW; i++) b[i] = bv[i];
  endtask

  function automatic logic [QW-1:0] q_le();
    logic [QW-1:0] v;
    for (int i = 0; i < QW; i++) v[i] = q[i];
    return v;
  endfunction

  function automatic logic [RW-1:0] r_le();
    logic [RW-1:0] v;
    for (int i = 0; i < RW; i++) v[i] = r[i];
    return v;
  endfunction

  function automatic logic [AW-1:0] clmul(input logic [QW-1:0] x, input logic [BW-1:0] y);
    logic [AW-1:0] p;
    p = '0;
    for (int i = 0; i < QW; i++)
      if (x[i]) p = p ^ (AW'(y) << i);
    return p;
  endfunction

  // ---------------- driver ----------------
  // Offers one job, waits for the result, holds it for 'hold' cycles (pulsing
  // in_valid in between) and then hands it off.
  task automatic run_job(input logic [AW-1:0] av, input logic [BW-1:0] bv,
                         input int hold,
                         output logic [QW-1:0] gq, output logic [RW-1:0] gr,
                         output logic gerr, output int lat);
    drive_ab(av, bv);
    in_valid = 1'b1;
    chk("in_ready_before_accept", 32'(in_ready), 1);
    tick;
    in_valid = 1'b0;
    chk("in_ready_after_accept", 32'(in_ready), 0);
    // Inputs change after the accept edge; the job must not notice.
    drive_ab(AW'($urandom), BW'($urandom));
    lat = 0;
    while (!out_valid && lat < 64) begin
      tick;
      lat++;
    end
    gq   = q_le();
    gr   = r_le();
    gerr = err;
    if (out_valid && !err)
      chk("rem_high_bits_zero", 32'(dut.rem_q >> (BW - 1)), 0);
    for (int h = 0; h < hold; h++) begin
      if (h == 2) begin
        drive_ab(AW'($urandom), 14'h2001);
        in_valid = 1'b1;
      end
      tick;
      in_valid = 1'b0;
      chk("hold_out_valid", 32'(out_valid), 1);
      chk("hold_in_ready", 32'(in_ready), 0);
      chk("hold_q", 32'(q_le()), 32'(gq));
      chk("hold_r", 32'(r_le()), 32'(gr));
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("handoff_out_valid", 32'(out_valid), 0);
    chk("handoff_in_ready", 32'(in_ready), 1);
    chk("handoff_err", 32'(err), 0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    string         name;
    logic [AW-1:0] av;
    logic [BW-1:0] bv;
    logic [QW-1:0] eq;
    logic [RW-1:0] er;
    logic          eerr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [QW-1:0] gq;
    logic [RW-1:0] gr;
    logic          gerr;
    int            lat;
    logic [QW+RW:0] e;

    vecs[0] = '{"x26_div_x13p1",  27'h4000000, 14'h2001, 14'h2001, 13'h0001, 1'b0};
    vecs[1] = '{"exact_product",  27'h004806C, 14'h2003, 14'h0024, 13'h0000, 1'b0};
    vecs[2] = '{"non_monic_err",  27'h05A5A5A, 14'h1001, 14'h0000, 13'h0000, 1'b1};
    vecs[3] = '{"deg_a_below_b",  27'h0001008, 14'h2011, 14'h0000, 13'h1008, 1'b0};
    vecs[4] = '{"a_equals_b",     27'h0002003, 14'h2003, 14'h0001, 13'h0000, 1'b0};
    vecs[5] = '{"x13_div_b",      27'h0002000, 14'h2003, 14'h0001, 13'h0003, 1'b0};
    vecs[6] = '{"zero_dividend",  27'h0000000, 14'h2001, 14'h0000, 13'h0000, 1'b0};
    vecs[7] = '{"all_ones_by_x13",27'h7FFFFFF, 14'h2000, 14'h3FFF, 13'h1FFF, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive_ab('0, '0);

    // reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_q", 32'(q_le()), 0);
    chk("rst_r", 32'(r_le()), 0);
    chk("rst_err", 32'(err), 0);
    tick;
    rst_n = 1'b1;

    // table-driven directed divisions
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({vecs[i].eq, vecs[i].er, vecs[i].eerr});
      run_job(vecs[i].av, vecs[i].bv, 0, gq, gr, gerr, lat);
      e = exp_q.pop_front();
      chk({vecs[i].name, "_latency"}, 32'(lat), vecs[i].eerr ? 0 : QW);
      chk({vecs[i].name, "_q"}, 32'(gq), 32'(e[QW+RW:RW+1]));
      chk({vecs[i].name, "_r"}, 32'(gr), 32'(e[RW:1]));
      chk({vecs[i].name, "_err"}, 32'(gerr), 32'(e[0]));
    end

    // back-pressure: result held 5 cycles with an in_valid pulse, then the
    // next job is offered on the edge right after the handoff
    run_job(27'h4000000, 14'h2001, 5, gq, gr, gerr, lat);
    chk("bp_q", 32'(gq), 32'h2001);
    chk("bp_r", 32'(gr), 1);
    run_job(27'h004806C, 14'h2003, 0, gq, gr, gerr, lat);
    chk("bp_next_latency", 32'(lat), QW);
    chk("bp_next_q", 32'(gq), 32'h0024);
    chk("bp_next_r", 32'(gr), 0);

    // reset during RUN step 7
    drive_ab(27'h4000000, 14'h2001);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (6) tick;
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_out_valid", 32'(out_valid), 0);
    chk("midrun_rst_q", 32'(q_le()), 0);
    chk("midrun_rst_r", 32'(r_le()), 0);
    chk("midrun_rst_err", 32'(err), 0);
    chk("midrun_rst_in_ready", 32'(in_ready), 1);
    #2;
    rst_n = 1'b1;
    run_job(27'h0002000, 14'h2003, 0, gq, gr, gerr, lat);
    chk("post_rst_latency", 32'(lat), QW);
    chk("post_rst_q", 32'(gq), 1);
    chk("post_rst_r", 32'(gr), 3);

    // random monic divisions checked by multiplication
    for (int n = 0; n < 1000; n++) begin
      logic [AW-1:0] av;
      logic [BW-1:0] bv;
      av = AW'($urandom);
      bv = {1'b1, RW'($urandom)};
      run_job(av, bv, 0, gq, gr, gerr, lat);
      chk("rand_latency", 32'(lat), QW);
      chk("rand_err", 32'(gerr), 0);
      chk("rand_qb_xor_r", 32'(clmul(gq, bv) ^ AW'(gr)), 32'(av));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gf2_polydiv.md
Name: gf2_polydiv

Overview:
- Bit-serial GF(2) polynomial divider; the inverse of the team's carry-less Karatsuba multipliers.
- Takes a product-width dividend and a monic divisor, and returns quotient and remainder so that a = q*b XOR r, with the product carry-less.
- Sits behind the multiplier array for field reduction and for self-checks of multiplier results.
- Uses a valid/ready handshake on both input and output, and processes one quotient bit per cycle.

Parameters:
- AW, 27, dividend width (coefficients x^0..x^(AW-1)).
- BW, 14, divisor width; divisor degree is exactly BW-1.
- Derived, not overridable: QW = AW-BW+1 (14), quotient width; RW = BW-1 (13), remainder width.
- Legal range: 2 <= BW <= AW.

Ports:
- clk  in  1  sole clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  dividend/divisor offered.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  [0:AW-1]  dividend; a[i] is the coefficient of x^i.
- b  in  [0:BW-1]  divisor; b[i] is the coefficient of x^i.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes result.
- q  out  [0:QW-1]  quotient; q[i] is the coefficient of x^i.
- r  out  [0:RW-1]  remainder; degree < BW-1.
- err  out  1  divisor rejected (b[BW-1]=0).

Behaviour:
- Reset (rst_n low, async) puts state in IDLE and clears the remainder register R[0:AW-1], the latched divisor, q, r, err, out_valid and the step counter to 0.
- in_ready = (state==IDLE), so it reads 1 while in reset; no transfer occurs while rst_n is low.
- States: IDLE, RUN, DONE.
- IDLE:
  - On the edge where in_valid and in_ready are both high, latch b and load R <= a, q <= 0, cnt <= 0.
  - If b[BW-1]=1: go to RUN.
  - If b[BW-1]=0: go directly to DONE with err=1, q=0, r=0; no RUN cycles.
- RUN, one step per edge:
  - i = AW-1-cnt.
  - If R[i]=1: q[i-(BW-1)] <= 1 and R <= R XOR (b shifted up by i-(BW-1)).
  - Else: no change.
  - cnt increments each step.
  - After step QW (cnt reaches QW-1 at step start): r <= R[0:RW-1] post-update, state goes to DONE.
- Latency: for an accept on edge k, out_valid is high after edge k+QW (14 with defaults). Error path: out_valid is high after edge k.
- DONE:
  - out_valid=1; q, r and err are held stable.
  - On an edge with out_ready=1: out_valid <= 0, err <= 0, state goes to IDLE. q and r keep their last values.
  - in_valid is ignored in DONE and RUN.
  - Minimum issue interval: QW+2 cycles (accept, QW steps, handoff).
- q, r and err are only meaningful while out_valid=1.
- Bits of R at or above BW-1 are zero at DONE; the bench checks this as an internal assertion.
- Arithmetic is XOR/AND only, with no carries.
- Shift index range: 0..QW-1. The counter is ceil(log2(QW)) bits and never wraps within a job.
- Reset mid-RUN or mid-DONE aborts the job: outputs return to reset values and the partial result is discarded. The first accept is allowed on the first clock edge after rst_n deasserts.
- a and b are sampled only on the accept edge. Later changes have no effect on the job in flight.

Test Plan:
1. a=x^26, b=x^13+1 -> out_valid 14 cycles after accept; q=x^13+1, r=1, err=0.
2. a=(x^13+x+1)*(x^5+x^2)=x^18+x^15+x^6+x^5+x^3+x^2, b=x^13+x+1 -> q=x^5+x^2, r=0.
3. a=x^12+x^3, b=x^13+x^4+1 -> q=0, r=x^12+x^3 (dividend degree below divisor degree).
4. b=x^12+1 (top bit clear), any a -> out_valid after 1 cycle, err=1, q=0, r=0; next job is accepted normally and err=0.
5. Job completes with out_ready held low 5 cycles, in_valid pulsed meanwhile:
   - q, r and out_valid stay stable; in_ready stays 0; the pulse is not accepted.
   - out_ready high -> IDLE on that edge; the next accept occurs one edge later.
6. Further coverage:
   - rst_n low during RUN step 7 -> immediately out_valid=0, q=0, r=0, err=0, in_ready=1.
   - After release, a fresh job returns the correct result.
   - 1000 random a with random monic b checked against a carry-less multiply model: q*b XOR r == a and deg r < 13.
